// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbitration of NUM_REQ writers onto the single
// register-file write port. The winner lands in a one-entry output stage, which
// drives a decoded one-hot write enable until the register file stops stalling.
// Optional build macro: RF_WRITE_ARB_X0_DROP_EN. When it is defined, writes to
// address 0 are accepted and pass through the stage, but they raise no enable.
module rf_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          wr_stall,
  output logic [(2**ADDR_WIDTH)-1:0]    wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic                  out_valid;
  logic [ID_W-1:0]       rr_ptr;
  logic                  found;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       nxt_ptr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  transfer;
  logic                  commit;

  // The stage can take a new entry when it is empty, or when its current
  // entry commits in this same cycle. That overlap sustains one write per cycle.
  assign accept   = !out_valid || !wr_stall;
  assign commit   = out_valid && !wr_stall;
  assign transfer = !rst && found && accept;

  // Scan from rr_ptr and wrap around. The first valid requester found wins.
  always_comb begin
    int            cand_i;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand_i = 0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_i = int'(rr_ptr) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = ID_W'(cand_i);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the winner's address and data with constant slices.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The pointer moves to the requester just after the winner.
  assign nxt_ptr = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);

  // Only the winner sees ready, and only when the stage can take its entry.
  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[winner] = 1'b1;
  end

  // Decode the pending address. The register file itself ignores wr_en while it stalls.
  always_comb begin
    wr_en = '0;
    if (out_valid) wr_en[wr_addr] = 1'b1;
`ifdef RF_WRITE_ARB_X0_DROP_EN
    // x0 is hardwired to zero, so a write to it is swallowed here.
    if (wr_addr == '0) wr_en = '0;
`else
`endif
  end

  // Output stage and round-robin pointer. A transfer has priority over
  // emptying the stage on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      wr_addr   <= sel_addr;
      wr_data   <= sel_data;
      grant_id  <= winner;
      rr_ptr    <= nxt_ptr;
    end else if (commit) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter. Directed scenarios come first, followed by a
// randomized run. Each cycle is compared against an abstract model of the
// stage, built from a pending flag, its contents and a priority index.
module tb_rf_write_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int NW = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_data;
  logic               wr_stall;
  logic [NW-1:0]      wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [IW-1:0]      grant_id;

  rf_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: is a write pending, what it holds, and who has priority.
  bit          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_id;
  int          m_ptr;
  int          last_acc;
  int          wait_cnt [NR];

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r = '0;
    if (rst) return r;
    for (int k = 0; k < NR; k++) begin
      int i = (m_ptr + k) % NR;
      if (req_valid[i]) begin
        if (!m_valid || !wr_stall) r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] exp_wr_en();
    logic [NW-1:0] e = '0;
    if (m_valid) e = NW'(1) << m_addr;
`ifdef RF_WRITE_ARB_X0_DROP_EN
    if (m_addr == 0) e = '0;
`endif
    return e;
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    logic [NR-1:0] r;
    r = exp_ready();
    last_acc = -1;
    if (rst) begin
      m_valid = 0; m_addr = '0; m_data = '0; m_id = 0; m_ptr = 0;
    end else if (r != '0) begin
      for (int i = 0; i < NR; i++) if (r[i]) last_acc = i;
      m_addr  = req_addr[last_acc*AW +: AW];
      m_data  = req_data[last_acc*DW +: DW];
      m_id    = last_acc;
      m_ptr   = (last_acc + 1) % NR;
      m_valid = 1;
    end else if (m_valid && !wr_stall) begin
      m_valid = 0;
    end
  endtask

  // Clock edge: update the model, then drop the valid of the accepted requester.
  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
    if (last_acc >= 0) req_valid[last_acc] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_stall = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 10);
      req_data[i*DW +: DW] = $urandom;
    end
    repeat (2) begin
      advance();
      @(negedge clk);
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      n_cmp++; if (wr_en !== '0) begin n_bad++; $display("FAIL reset_wr_en: got %h want 0", wr_en); end
      n_cmp++; if (grant_id !== '0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
      n_cmp++; if (wr_addr !== '0 || wr_data !== '0) begin n_bad++; $display("FAIL reset_regs: got %h/%h want 0/0", wr_addr, wr_data); end
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
    for (int k = 0; k < NR; k++) begin
      advance();
      @(negedge clk);
      n_cmp++; if (grant_id !== IW'(k)) begin n_bad++; $display("FAIL reset_drain_grant: got %0d want %0d", grant_id, k); end
      n_cmp++; if (req_ready !== exp_ready()) begin n_bad++; $display("FAIL reset_drain_ready: got %b want %b", req_ready, exp_ready()); end
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_single();
    set_req(2, 5'd7, 32'hDEADBEEF);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    advance();
    @(negedge clk);
    n_cmp++; if (wr_en !== 32'h0000_0080) begin n_bad++; $display("FAIL single_wr_en: got %h want 00000080", wr_en); end
    n_cmp++; if (wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_wr_data: got %h want deadbeef", wr_data); end
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    advance();
  endtask

  task automatic test_back_to_back();
    set_req(3, 5'd9, 32'h3333_0009);
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL b2b_ready: got %b want 1000", req_ready); end
    advance();
    @(negedge clk);
    n_cmp++; if (grant_id !== 2'd3 || wr_en !== 32'h0000_0200) begin n_bad++; $display("FAIL b2b_write: got id %0d en %h want id 3 en 00000200", grant_id, wr_en); end
    advance();
    @(negedge clk);
    n_cmp++; if (wr_en !== '0) begin n_bad++; $display("FAIL b2b_empty: got %h want 0", wr_en); end
    n_cmp++; if (wr_data !== 32'h3333_0009) begin n_bad++; $display("FAIL b2b_hold: got %h want 33330009", wr_data); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) if (!req_valid[i]) set_req(i, AW'(i + 1), 32'hA000_0000 + i);
      #1;
      n_cmp++; if (req_ready !== NR'(1 << (k % NR))) begin n_bad++; $display("FAIL rr_ready: got %b want %b", req_ready, NR'(1 << (k % NR))); end
      advance();
      @(negedge clk);
      n_cmp++; if (grant_id !== IW'(k % NR)) begin n_bad++; $display("FAIL rr_grant: got %0d want %0d", grant_id, k % NR); end
      n_cmp++; if (wr_en !== NW'(1) << (k % NR + 1)) begin n_bad++; $display("FAIL rr_wr_en: got %h want %h", wr_en, NW'(1) << (k % NR + 1)); end
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_stall();
    set_req(0, 5'd31, 32'h5151_5151);
    advance();
    @(negedge clk);
    wr_stall = 1'b1;
    set_req(1, 5'd12, 32'h1212_1212);
    repeat (3) begin
      #1;
      n_cmp++; if (wr_en !== 32'h8000_0000) begin n_bad++; $display("FAIL stall_wr_en: got %h want 80000000", wr_en); end
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", req_ready); end
      advance();
    end
    wr_stall = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_release: got %b want 0010", req_ready); end
    advance();
    @(negedge clk);
    n_cmp++; if (grant_id !== 2'd1 || wr_data !== 32'h1212_1212) begin n_bad++; $display("FAIL stall_next: got id %0d data %h want 1/12121212", grant_id, wr_data); end
    advance();
  endtask

  task automatic test_x0();
    set_req(0, 5'd0, 32'h0F0F_0F0F);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL x0_ready: got %b want 0001", req_ready); end
    advance();
    @(negedge clk);
`ifdef RF_WRITE_ARB_X0_DROP_EN
    n_cmp++; if (wr_en !== 32'h0) begin n_bad++; $display("FAIL x0_wr_en: got %h want 0", wr_en); end
`else
    n_cmp++; if (wr_en !== 32'h0000_0001) begin n_bad++; $display("FAIL x0_wr_en: got %h want 00000001", wr_en); end
`endif
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL x0_grant: got %0d want 0", grant_id); end
    set_req(0, 5'd4, 32'h4);
    set_req(1, 5'd5, 32'h5);
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL x0_ptr: got %b want 0010", req_ready); end
    repeat (3) advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst      = ($urandom_range(0, 49) == 0);
      wr_stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, AW'($urandom), $urandom);
          wait_cnt[i] = 0;
        end
      #1;
      n_cmp++; if (req_ready !== exp_ready()) begin n_bad++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, req_ready, exp_ready()); end
      n_cmp++; if (wr_en !== exp_wr_en()) begin n_bad++; $display("FAIL rand_wr_en c%0d: got %h want %h", cyc, wr_en, exp_wr_en()); end
      n_cmp++; if (grant_id !== IW'(m_id)) begin n_bad++; $display("FAIL rand_grant c%0d: got %0d want %0d", cyc, grant_id, m_id); end
      n_cmp++; if (wr_addr !== m_addr || wr_data !== m_data) begin n_bad++; $display("FAIL rand_regs c%0d: got %h/%h want %h/%h", cyc, wr_addr, wr_data, m_addr, m_data); end
      advance();
      if (rst) begin
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
      end else if (last_acc >= 0) begin
        n_cmp++; if (wait_cnt[last_acc] > NR - 1) begin n_bad++; $display("FAIL rand_fair: req %0d waited %0d want <= %0d", last_acc, wait_cnt[last_acc], NR - 1); end
        for (int i = 0; i < NR; i++) if (req_valid[i]) wait_cnt[i]++;
      end
    end
    rst = 1'b0; wr_stall = 1'b0; req_valid = '0;
    repeat (2) advance();
  endtask

  initial begin
    rst = 1'b1; wr_stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_stall();
    test_x0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register-file write port between NUM_REQ requesters, e.g. ALU writeback, load unit and CSR unit.
- Arbitration is round-robin with a valid/ready handshake.
- The winning request goes into a single-entry output stage. That stage drives the register file's one-hot write-enable vector, produced by an internal 2**ADDR_WIDTH decoder, together with the write data.
- The stage holds while the register file asserts wr_stall.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 5, register address width; write-enable vector is 2**ADDR_WIDTH bits.
- DATA_WIDTH, 32, write data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- wr_stall  in  1  register file cannot commit this cycle.
- wr_en  out  2**ADDR_WIDTH  one-hot write enable, all-zero when no write.
- wr_addr  out  ADDR_WIDTH  registered address of the pending write.
- wr_data  out  DATA_WIDTH  registered write data.
- grant_id  out  $clog2(NUM_REQ)  index of the requester owning the output stage.

Behaviour:
- State:
  - out_valid (1 bit), the output register (addr, data, id), and rr_ptr, the highest-priority requester index.
- Reset (rst=1 at a clock edge):
  - out_valid=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0, rr_ptr=0.
  - req_ready is all-zero while rst=1.
  - Reset mid-operation discards the pending write; no commit occurs that cycle.
- Commit:
  - A commit occurs in a cycle with out_valid=1 and wr_stall=0.
  - wr_en is combinational: decode(wr_addr) when out_valid=1, otherwise all-zero.
  - wr_en does not depend on wr_stall; the register file ignores wr_en while it stalls.
- Accept condition:
  - accept = !out_valid || (out_valid && !wr_stall).
  - A new request may enter in the same cycle the old one commits, so sustained throughput is 1 write/cycle.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner]=accept; all other bits are 0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - On transfer at the edge: output register <= {req_addr[i], req_data[i], i}, out_valid<=1, rr_ptr <= (i+1) mod NUM_REQ.
  - If there is no transfer and a commit happens: out_valid<=0.
  - wr_addr, wr_data and grant_id hold their last values when out_valid=0.
- Requester obligation:
  - Once req_valid is high, the requester keeps it high with stable addr/data until accepted.
- Stall:
  - While wr_stall=1 and out_valid=1, all outputs hold and req_ready is all-zero.
- Fairness:
  - With all requesters continuously valid and no stall, grants rotate 0,1,2,...,NUM_REQ-1,0.
  - Each requester waits at most NUM_REQ-1 accepted transfers.
- No valid requests:
  - rr_ptr unchanged, req_ready all-zero.
- Latency:
  - Request accepted at edge N; wr_en is valid during cycle N+1; commit no earlier than edge N+1.

Optional Feature:
- Macro: RF_WRITE_ARB_X0_DROP_EN.
- Defined:
  - Requests with address 0 are still handshaken normally and occupy the output stage.
  - wr_en is forced all-zero for them (RISC-V x0 hardwired zero), and rr_ptr advances.
- Undefined:
  - Address 0 decodes normally (wr_en=32'h0000_0001 for ADDR_WIDTH=5).

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles while req_valid=4'b1111 and wr_stall=0.
  - Expected: req_ready=0, wr_en=0, grant_id=0; after release, the first grant goes to requester 0.
- Single request:
  - Stimulus: req_valid=4'b0100, addr=5'd7, data=32'hDEADBEEF.
  - Expected: req_ready=4'b0100 in the same cycle; next cycle wr_en=32'h0000_0080, wr_data=32'hDEADBEEF, grant_id=2.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held for 8 cycles, each requester using distinct addresses 1..4.
  - Expected: grant_id sequence 0,1,2,3,0,1,2,3; one write per cycle.
- Stall:
  - Stimulus: write pending to addr 5'd31, wr_stall=1 for 3 cycles, requester 1 valid.
  - Expected: wr_en=32'h8000_0000 is held and req_ready=0 throughout; requester 1 is accepted in the cycle wr_stall drops.
- Back-to-back commit and accept, then empty:
  - Stimulus: requester 3 valid for 1 transfer, then idle.
  - Expected: out_valid deasserts after commit, wr_en=0, rr_ptr=0.
- x0 write:
  - Stimulus: request addr=0.
  - Expected: with RF_WRITE_ARB_X0_DROP_EN, handshake completes and wr_en stays 0; without it, wr_en=32'h0000_0001.
